imem_load_arbiter: RTL and testbench

Owns the single port of the instruction memory and shares it between two requesters: the boot/program loader, which streams 32-bit words in over a valid/ready handshake, and the CPU fetch stage. The CPU is held off (`CpuHold`) until a load completes. In RUN, the block turns fetch requests into memory reads and returns each instruction one cycle later. It sits between the top-level loader, the PC/fetch logic, and an instruction memory with synchronous write and synchronous (1-cycle) read.

---
 rtl/imem_load_arbiter_if.sv | 36 +++
 rtl/imem_load_arbiter.sv | 108 ++++++++++
 tb/tb_imem_load_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_load_arbiter_if.sv
// Bundle of loader, fetch and instruction-memory signals around imem_load_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system (loader, CPU, memory).
interface imem_load_arbiter_if #(
  parameter int DEPTH  = 11,
  parameter int ADDR_W = 4
);
  logic              LoadStart;
  logic [ADDR_W:0]   LoadLen;
  logic [31:0]       LoadData;
  logic              LoadValid;
  logic              LoadReady;
  logic              LoadDone;
  logic              LoadErr;
  logic              FetchReq;
  logic [31:0]       FetchAddr;
  logic [31:0]       FetchInstr;
  logic              FetchValid;
  logic              AddrFault;
  logic              CpuHold;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemWe;
  logic [31:0]       MemWrData;
  logic [31:0]       MemRdData;

  modport slave (
    input  LoadStart, LoadLen, LoadData, LoadValid, FetchReq, FetchAddr, MemRdData,
    output LoadReady, LoadDone, LoadErr, FetchInstr, FetchValid, AddrFault, CpuHold,
           MemAddr, MemWe, MemWrData
  );

  modport master (
    output LoadStart, LoadLen, LoadData, LoadValid, FetchReq, FetchAddr, MemRdData,
    input  LoadReady, LoadDone, LoadErr, FetchInstr, FetchValid, AddrFault, CpuHold,
           MemAddr, MemWe, MemWrData
  );
endinterface

// File: rtl/imem_load_arbiter.sv
// Shares the instruction memory port between the program loader and CPU fetch.
// CPU is held until a load completes; fetches return one cycle after the request.
module imem_load_arbiter #(
  parameter int DEPTH  = 11,
  parameter int ADDR_W = 4
) (
  input  logic Clk,
  input  logic Rst,
  imem_load_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              fv_q, fv_d;
  logic              flt_q, flt_d;
  logic              len_ok, last;

  assign len_ok = (bus.LoadLen != '0) && (bus.LoadLen <= (ADDR_W+1)'(DEPTH));
  assign last   = ({1'b0, wptr_q} == (len_q - (ADDR_W+1)'(1)));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fv_q    <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      flt_q   <= flt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    len_d         = len_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    fv_d          = 1'b0;
    flt_d         = 1'b0;
    bus.MemWe     = 1'b0;
    bus.MemAddr   = '0;
    bus.MemWrData = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.LoadStart) begin
          if (len_ok) begin
            wptr_d  = '0;
            len_d   = bus.LoadLen;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (bus.LoadValid) begin
          bus.MemWe     = 1'b1;
          bus.MemAddr   = wptr_q;
          bus.MemWrData = bus.LoadData;
          wptr_d        = wptr_q + ADDR_W'(1);
          if (last) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        // Full 32-bit compare so high address bits cannot alias into range.
        if (bus.FetchReq) begin
          fv_d        = 1'b1;
          flt_d       = (bus.FetchAddr >= 32'(DEPTH));
          bus.MemAddr = bus.FetchAddr[ADDR_W-1:0];
        end
        if (bus.LoadStart) begin
          if (len_ok) begin
            wptr_d  = '0;
            len_d   = bus.LoadLen;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.LoadReady  = (state_q == LOAD);
  assign bus.CpuHold    = (state_q != RUN);
  assign bus.LoadDone   = done_q;
  assign bus.LoadErr    = err_q;
  assign bus.FetchValid = fv_q;
  assign bus.AddrFault  = flt_q;
  assign bus.FetchInstr = !fv_q ? 32'h0 : (flt_q ? 32'hFFFF_FFFF : bus.MemRdData);
endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter with a 1-cycle synchronous memory model.
module tb_imem_load_arbiter;
  localparam int DEPTH  = 11;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  logic [31:0] mem     [16];
  logic [31:0] exp_mem [16];

  imem_load_arbiter_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  imem_load_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.MemWe) mem[bus.MemAddr] <= bus.MemWrData;
    bus.MemRdData <= mem[bus.MemAddr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.LoadStart = 1'b0;
    bus.LoadLen   = '0;
    bus.LoadData  = '0;
    bus.LoadValid = 1'b0;
    bus.FetchReq  = 1'b0;
    bus.FetchAddr = '0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_hold"},  32'(bus.CpuHold),    32'd1);
    chk({tag, "_rdy"},   32'(bus.LoadReady),  32'd0);
    chk({tag, "_done"},  32'(bus.LoadDone),   32'd0);
    chk({tag, "_err"},   32'(bus.LoadErr),    32'd0);
    chk({tag, "_fv"},    32'(bus.FetchValid), 32'd0);
    chk({tag, "_flt"},   32'(bus.AddrFault),  32'd0);
    chk({tag, "_instr"}, bus.FetchInstr,      32'd0);
    chk({tag, "_we"},    32'(bus.MemWe),      32'd0);
    chk({tag, "_addr"},  32'(bus.MemAddr),    32'd0);
    chk({tag, "_wdata"}, bus.MemWrData,       32'd0);
  endtask

  // Drive one accepted word in LOAD and check the combinational write port.
  task automatic load_word(input string tag, input int idx, input logic [31:0] w);
    bus.LoadValid = 1'b1;
    bus.LoadData  = w;
    #1;
    chk({tag, "_we"},    32'(bus.MemWe),     32'd1);
    chk({tag, "_addr"},  32'(bus.MemAddr),   32'(idx));
    chk({tag, "_wdata"}, bus.MemWrData,      w);
    chk({tag, "_hold"},  32'(bus.CpuHold),   32'd1);
    chk({tag, "_rdy"},   32'(bus.LoadReady), 32'd1);
    exp_mem[idx] = w;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'hDEAD_0000 + 32'(i);
      exp_mem[i] = 32'hDEAD_0000 + 32'(i);
    end
    bus.MemRdData = '0;
    idle_inputs();
    tick();
    tick();
    chk_reset_outs("rst");
    rst = 1'b0;
    tick();

    // Load 8 words back to back
    bus.LoadStart = 1'b1;
    bus.LoadLen   = 5'd8;
    #1;
    chk("l8_idle_rdy", 32'(bus.LoadReady), 32'd0);
    tick();
    bus.LoadStart = 1'b0;
    for (int i = 0; i < 8; i++) load_word("l8", i, 32'hA000_0000 + 32'(i));
    bus.LoadValid = 1'b0;
    #1;
    chk("l8_done",   32'(bus.LoadDone), 32'd1);
    chk("l8_hold",   32'(bus.CpuHold),  32'd0);
    chk("l8_we_off", 32'(bus.MemWe),    32'd0);
    tick();
    chk("l8_done_pulse", 32'(bus.LoadDone), 32'd0);

    // Back-to-back fetches 2,3,6
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = 32'd2;
    #1;
    chk("bb_maddr", 32'(bus.MemAddr), 32'd2);
    chk("bb_fv0",   32'(bus.FetchValid), 32'd0);
    tick();
    bus.FetchAddr = 32'd3;
    #1;
    chk("bb_fv2", 32'(bus.FetchValid), 32'd1);
    chk("bb_i2",  bus.FetchInstr, exp_mem[2]);
    chk("bb_af2", 32'(bus.AddrFault), 32'd0);
    tick();
    bus.FetchAddr = 32'd6;
    #1;
    chk("bb_i3", bus.FetchInstr, exp_mem[3]);
    tick();
    bus.FetchReq = 1'b0;
    #1;
    chk("bb_fv6", 32'(bus.FetchValid), 32'd1);
    chk("bb_i6",  bus.FetchInstr, exp_mem[6]);
    tick();
    chk("bb_fv_off", 32'(bus.FetchValid), 32'd0);

    // Out-of-range fetches: 11, 16, and a high-bit address
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = 32'd11;
    tick();
    bus.FetchAddr = 32'h0000_0010;
    #1;
    chk("oor11_i",  bus.FetchInstr, 32'hFFFF_FFFF);
    chk("oor11_af", 32'(bus.AddrFault), 32'd1);
    tick();
    bus.FetchAddr = 32'h8000_0001;
    #1;
    chk("oor16_i",  bus.FetchInstr, 32'hFFFF_FFFF);
    chk("oor16_af", 32'(bus.AddrFault), 32'd1);
    tick();
    bus.FetchAddr = 32'd10;
    #1;
    chk("oorhi_i",  bus.FetchInstr, 32'hFFFF_FFFF);
    chk("oorhi_af", 32'(bus.AddrFault), 32'd1);
    tick();
    bus.FetchReq = 1'b0;
    #1;
    chk("inr10_i",  bus.FetchInstr, exp_mem[10]);
    chk("inr10_af", 32'(bus.AddrFault), 32'd0);

    // Illegal length while in RUN
    bus.LoadStart = 1'b1;
    bus.LoadLen   = 5'd0;
    tick();
    bus.LoadStart = 1'b0;
    #1;
    chk("run_err",  32'(bus.LoadErr), 32'd1);
    chk("run_hold", 32'(bus.CpuHold), 32'd0);

    // LoadStart from RUN with same-cycle fetch, then gapped 3-word load
    bus.LoadStart = 1'b1;
    bus.LoadLen   = 5'd3;
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = 32'd5;
    #1;
    chk("rl_hold0", 32'(bus.CpuHold), 32'd0);
    chk("rl_maddr", 32'(bus.MemAddr), 32'd5);
    tick();
    bus.LoadStart = 1'b0;
    bus.FetchReq  = 1'b0;
    #1;
    chk("rl_fv",    32'(bus.FetchValid), 32'd1);
    chk("rl_i5",    bus.FetchInstr, exp_mem[5]);
    chk("rl_hold1", 32'(bus.CpuHold), 32'd1);
    load_word("gap0", 0, 32'hB000_0000);
    bus.LoadValid = 1'b0;
    #1;
    chk("gap_we_a", 32'(bus.MemWe), 32'd0);
    tick();
    load_word("gap1", 1, 32'hB000_0001);
    bus.LoadValid = 1'b0;
    #1;
    chk("gap_we_b", 32'(bus.MemWe), 32'd0);
    chk("gap_hold", 32'(bus.CpuHold), 32'd1);
    tick();
    load_word("gap2", 2, 32'hB000_0002);
    bus.LoadValid = 1'b0;
    #1;
    chk("gap_done", 32'(bus.LoadDone), 32'd1);
    chk("gap_hold_off", 32'(bus.CpuHold), 32'd0);
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = 32'd2;
    tick();
    bus.FetchAddr = 32'd7;
    #1;
    chk("gap_rd2", bus.FetchInstr, 32'hB000_0002);
    tick();
    bus.FetchReq = 1'b0;
    #1;
    chk("gap_rd7_old", bus.FetchInstr, 32'hA000_0007);

    // Reset back to IDLE, then illegal lengths
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    bus.LoadStart = 1'b1;
    bus.LoadLen   = 5'd0;
    tick();
    bus.LoadStart = 1'b0;
    #1;
    chk("il0_err",  32'(bus.LoadErr), 32'd1);
    chk("il0_hold", 32'(bus.CpuHold), 32'd1);
    tick();
    chk("il0_pulse", 32'(bus.LoadErr), 32'd0);
    bus.LoadStart = 1'b1;
    bus.LoadLen   = 5'd12;
    tick();
    bus.LoadStart = 1'b0;
    #1;
    chk("il12_err",  32'(bus.LoadErr), 32'd1);
    chk("il12_rdy",  32'(bus.LoadReady), 32'd0);
    chk("il12_hold", 32'(bus.CpuHold), 32'd1);

    // Reset after 2 of 5 words, then reload 5 from address 0
    tick();
    bus.LoadStart = 1'b1;
    bus.LoadLen   = 5'd5;
    tick();
    bus.LoadStart = 1'b0;
    load_word("ab0", 0, 32'hC000_0000);
    load_word("ab1", 1, 32'hC000_0001);
    bus.LoadValid = 1'b1;
    bus.LoadData  = 32'hC000_0002;
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outs("abort");
    tick();
    rst = 1'b0;
    idle_inputs();
    tick();
    bus.LoadStart = 1'b1;
    bus.LoadLen   = 5'd5;
    tick();
    bus.LoadStart = 1'b0;
    for (int i = 0; i < 5; i++) load_word("rl5", i, 32'hD000_0000 + 32'(i));
    bus.LoadValid = 1'b0;
    #1;
    chk("rl5_done", 32'(bus.LoadDone), 32'd1);
    bus.FetchReq  = 1'b1;
    bus.FetchAddr = 32'd0;
    tick();
    bus.FetchAddr = 32'd5;
    #1;
    chk("rl5_rd0", bus.FetchInstr, 32'hD000_0000);
    tick();
    bus.FetchReq = 1'b0;
    #1;
    chk("rl5_rd5_old", bus.FetchInstr, 32'hA000_0005);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
